// File: rtl/gpu_wb_sequencer_if.sv
// Request/response and Wishbone master bundle for gpu_wb_sequencer.
// master: the sequencer side; slave: requester plus Wishbone slave side.
interface gpu_wb_sequencer_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [29:0] req_adr_i;
  logic [31:0] req_dat_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [29:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;
  logic        busy_o;
  logic        err_o;
  logic        err_clr_i;

  modport master (
    input  req_valid_i, req_we_i, req_adr_i, req_dat_i,
    input  rsp_ready_i, wbm_ack_i, wbm_dat_i, err_clr_i,
    output req_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
    output wbm_adr_o, wbm_dat_o, busy_o, err_o
  );

  modport slave (
    output req_valid_i, req_we_i, req_adr_i, req_dat_i,
    output rsp_ready_i, wbm_ack_i, wbm_dat_i, err_clr_i,
    input  req_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
    input  wbm_adr_o, wbm_dat_o, busy_o, err_o
  );
endinterface

// File: rtl/gpu_wb_sequencer.sv
// Queues GPU register requests and issues them one at a time as Wishbone
// single transfers; reads return a response, writes do not.
// Ports: wb_clk_i, wb_rst_i (async, active high), bus (gpu_wb_sequencer_if
// master: request, response, Wishbone master, busy/err status).
// Macro GPU_SEQ_TIMEOUT_EN enables the ack watchdog (TIMEOUT cycles).
module gpu_wb_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  gpu_wb_sequencer_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic        we;
    logic [29:0] adr;
    logic [31:0] dat;
  } ent_t;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  ent_t          mem [DEPTH];
  ent_t          head;
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          push, pop, tmo;

  state_t      st, st_n;
  logic        cyc, cyc_n, we, we_n;
  logic [3:0]  sel, sel_n;
  logic [29:0] adr, adr_n;
  logic [31:0] dat, dat_n;
  logic        rv, rv_n, re, re_n;
  logic [31:0] rd, rd_n;
  logic        err, err_n;

  // Ready depends only on the registered count, so a pop in the
  // same cycle never lets a push into a full FIFO.
  assign bus.req_ready_o = ~wb_rst_i & (cnt != FULL);
  assign push = bus.req_valid_i & bus.req_ready_o;
  assign pop  = (st == IDLE) & (cnt != '0);
  assign head = mem[rp];

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push)
      mem[wp] <= '{bus.req_we_i, bus.req_adr_i, bus.req_dat_i};
  end

`ifdef GPU_SEQ_TIMEOUT_EN
  logic [7:0] tcnt;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)       tcnt <= '0;
    else if (st == BUS) tcnt <= tcnt + 8'd1;
    else                tcnt <= '0;
  end

  // Fires on the last of TIMEOUT ack-less BUS cycles.
  assign tmo = (st == BUS) & ~bus.wbm_ack_i
             & (tcnt == 8'(TIMEOUT - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      st  <= IDLE;
      cyc <= 1'b0;
      we  <= 1'b0;
      sel <= '0;
      adr <= '0;
      dat <= '0;
      rv  <= 1'b0;
      re  <= 1'b0;
      rd  <= '0;
      err <= 1'b0;
    end else begin
      st  <= st_n;
      cyc <= cyc_n;
      we  <= we_n;
      sel <= sel_n;
      adr <= adr_n;
      dat <= dat_n;
      rv  <= rv_n;
      re  <= re_n;
      rd  <= rd_n;
      err <= err_n;
    end
  end

  always_comb begin
    st_n  = st;
    cyc_n = cyc;
    we_n  = we;
    sel_n = sel;
    adr_n = adr;
    dat_n = dat;
    rv_n  = rv;
    re_n  = re;
    rd_n  = rd;
    // A new timeout outranks a clear in the same cycle.
    err_n = (err & ~bus.err_clr_i) | tmo;
    unique case (st)
      IDLE: begin
        if (pop) begin
          st_n  = BUS;
          cyc_n = 1'b1;
          we_n  = head.we;
          sel_n = 4'hf;
          adr_n = head.adr;
          dat_n = head.dat;
        end
      end
      BUS: begin
        if (bus.wbm_ack_i || tmo) begin
          cyc_n = 1'b0;
          we_n  = 1'b0;
          sel_n = '0;
          if (we) begin
            st_n = IDLE;
          end else begin
            st_n = RESP;
            rv_n = 1'b1;
            re_n = tmo;
            rd_n = tmo ? 32'h0 : bus.wbm_dat_i;
          end
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          rv_n = 1'b0;
          st_n = IDLE;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  assign bus.wbm_cyc_o   = cyc;
  assign bus.wbm_stb_o   = cyc;
  assign bus.wbm_we_o    = we;
  assign bus.wbm_sel_o   = sel;
  assign bus.wbm_adr_o   = adr;
  assign bus.wbm_dat_o   = dat;
  assign bus.rsp_valid_o = rv;
  assign bus.rsp_dat_o   = rd;
  assign bus.rsp_err_o   = re;
  assign bus.err_o       = err;
  assign bus.busy_o      = (cnt != '0) | (st != IDLE);
endmodule
